// File: rtl/rf_writeback_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered LSU load returns into one
// registered register-file write per cycle. Optional forwarding ports under WB_BYPASS_EN.
module rf_writeback_arbiter #(
   parameter int unsigned addr_width_p   = 6,
   parameter int unsigned lsu_depth_p    = 4,
   parameter int unsigned starve_limit_p = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    alu_v_i,
   input  logic [addr_width_p-1:0] alu_rd_i,
   input  logic [31:0]             alu_data_i,
   input  logic                    lsu_v_i,
   input  logic [addr_width_p-1:0] lsu_rd_i,
   input  logic [31:0]             lsu_data_i,
   output logic                    lsu_ready_o,
   output logic                    alu_stall_o,
   output logic                    lsu_busy_o,
   output logic                    wen_o,
   output logic [addr_width_p-1:0] rd_addr_o,
   output logic [31:0]             write_data_o
`ifdef WB_BYPASS_EN
   ,
   input  logic [addr_width_p-1:0] byp_addr_i,
   output logic                    byp_hit_o,
   output logic [31:0]             byp_data_o
`endif
);

   localparam int unsigned ptr_w_lp    = $clog2(lsu_depth_p);
   localparam int unsigned cnt_w_lp    = ptr_w_lp + 1;
   localparam int unsigned starve_w_lp = $clog2(starve_limit_p + 1);
   localparam logic [cnt_w_lp-1:0]    depth_lp = cnt_w_lp'(lsu_depth_p);
   localparam logic [starve_w_lp-1:0] limit_lp = starve_w_lp'(starve_limit_p);

   logic [addr_width_p-1:0] fifo_rd_q   [lsu_depth_p];
   logic [31:0]             fifo_data_q [lsu_depth_p];
   logic [ptr_w_lp-1:0]     wr_ptr_q, rd_ptr_q;
   logic [cnt_w_lp-1:0]     count_q;
   logic [starve_w_lp-1:0]  starve_q;
   logic                    fifo_ne, enq, grant_lsu, grant_alu;

   assign fifo_ne     = (count_q != '0);
   assign lsu_busy_o  = fifo_ne;
   assign lsu_ready_o = (count_q != depth_lp) && !reset;
   assign enq         = lsu_v_i && lsu_ready_o;
   // A stall only diverts the grant when there is something to drain.
   assign grant_lsu   = fifo_ne && (alu_stall_o || !alu_v_i);
   assign grant_alu   = !grant_lsu && alu_v_i;

   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_rd_q[wr_ptr_q]   <= lsu_rd_i;
         fifo_data_q[wr_ptr_q] <= lsu_data_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (enq)       wr_ptr_q <= wr_ptr_q + 1'b1;
         if (grant_lsu) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({enq, grant_lsu})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_q    <= '0;
         alu_stall_o <= 1'b0;
      end else begin
         if (grant_lsu || !fifo_ne) begin
            starve_q <= '0;
         end else if (grant_alu) begin
            starve_q <= starve_q + 1'b1;
            if (starve_q == limit_lp - 1'b1) alu_stall_o <= 1'b1;
         end
         if (grant_lsu) alu_stall_o <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wen_o        <= 1'b0;
         rd_addr_o    <= '0;
         write_data_o <= '0;
      end else if (grant_lsu) begin
         wen_o        <= 1'b1;
         rd_addr_o    <= fifo_rd_q[rd_ptr_q];
         write_data_o <= fifo_data_q[rd_ptr_q];
      end else if (grant_alu) begin
         wen_o        <= 1'b1;
         rd_addr_o    <= alu_rd_i;
         write_data_o <= alu_data_i;
      end else begin
         wen_o <= 1'b0;
      end
   end

`ifdef WB_BYPASS_EN
   assign byp_hit_o  = wen_o && (rd_addr_o == byp_addr_i);
   assign byp_data_o = write_data_o;
`endif

endmodule
